txn_fsm: RTL and testbench

//   Transaction FSM directly downstream of the host command port. Accepts one decoded command (opcode, length,
//   24-bit address) per handshake and sequences SPI-flash byte frames to the QSPI byte controller:

---
 rtl/txn_fsm.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_txn_fsm.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txn_fsm.sv
// txn_fsm: sequences SPI-flash byte frames for one host command (READ, or
// WRITE = WREN, PAGE PROGRAM, RDSR poll) over a QSPI byte controller.
// Build option: TXN_FSM_FAST_READ_EN selects fast read (0Bh + one dummy
// byte); when undefined, plain read (03h) is used.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | cmd_ready high, waiting for a command
// CHECK      | one cycle: opcode / page-crossing validation
// RD_CMD     | frame: send read opcode
// RD_ADDR    | frame: send 3 address bytes, MSB first
// RD_DUMMY   | frame: fetch and discard one dummy byte (fast read only)
// RD_DATA    | frame: fetch bytes through the rd_data holding register
// WREN       | frame: send 06h
// PG_CMD     | frame: send 02h
// PG_ADDR    | frame: send 3 address bytes, MSB first
// PG_DATA    | frame: pass host write bytes through to tx
// POLL_CMD   | frame: send 05h
// POLL_RD    | frame: fetch status byte, test WIP (bit 0)
// GAP        | cs_n high for CS_GAP cycles, then go to ret_q
// DONE       | one cycle: txn_done (and txn_err) pulse
module txn_fsm #(
  parameter int OPCODE_WIDTH = 4,
  parameter int LEN_WIDTH    = 8,
  parameter int CS_GAP       = 4,
  parameter int POLL_MAX     = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [23:0]             cmd_addr,
  input  logic                    wr_data_valid,
  input  logic [7:0]              wr_data,
  output logic                    wr_data_ready,
  output logic                    rd_data_valid,
  output logic [7:0]              rd_data,
  input  logic                    rd_data_ready,
  output logic                    qspi_cs_n,
  output logic                    qspi_tx_valid,
  output logic [7:0]              qspi_tx_data,
  input  logic                    qspi_tx_ready,
  output logic                    qspi_rx_req,
  input  logic                    qspi_rx_valid,
  input  logic [7:0]              qspi_rx_data,
  output logic                    busy,
  output logic                    txn_done,
  output logic                    txn_err
);

  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam int PW     = LEN_WIDTH + 9;
  localparam logic [GAP_W-1:0]        GAP_LOAD  = GAP_W'(CS_GAP - 1);
  localparam logic [POLL_W-1:0]       POLL_LOAD = POLL_W'(POLL_MAX - 1);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE  = OPCODE_WIDTH'(2);
`ifdef TXN_FSM_FAST_READ_EN
  localparam logic [7:0] RD_OPC = 8'h0B;
  localparam bit         FAST   = 1'b1;
`else
  localparam logic [7:0] RD_OPC = 8'h03;
  localparam bit         FAST   = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_CMD, S_RD_ADDR, S_RD_DUMMY, S_RD_DATA, S_WREN,
    S_PG_CMD, S_PG_ADDR, S_PG_DATA, S_POLL_CMD, S_POLL_RD, S_GAP, S_DONE
  } state_t;

  state_t                    state_q, state_d, ret_q, ret_d;
  logic [OPCODE_WIDTH-1:0]   opc_q, opc_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [23:0]               addr_q, addr_d;
  logic [LEN_WIDTH:0]        byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
  logic [POLL_W-1:0]         poll_cnt_q, poll_cnt_d;
  logic                      outst_q, outst_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [7:0]                rd_data_q, rd_data_d;
  logic                      err_q, err_d;
  logic                      cs_n_q, cs_n_d;
  logic                      rx_hit, last_byte, page_cross;
  logic [7:0]                addr_byte;
  logic [PW-1:0]             page_end;

  function automatic logic in_frame(input state_t s);
    case (s)
      S_RD_CMD, S_RD_ADDR, S_RD_DUMMY, S_RD_DATA, S_WREN, S_PG_CMD,
      S_PG_ADDR, S_PG_DATA, S_POLL_CMD, S_POLL_RD: in_frame = 1'b1;
      default:                                     in_frame = 1'b0;
    endcase
  endfunction

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign qspi_cs_n     = cs_n_q;
  assign rd_data_valid = rd_valid_q;
  assign rd_data       = rd_data_q;

  // Helper decode: address byte select, last-byte and page-crossing tests.
  always_comb begin
    case (byte_cnt_q[1:0])
      2'd0:    addr_byte = addr_q[23:16];
      2'd1:    addr_byte = addr_q[15:8];
      default: addr_byte = addr_q[7:0];
    endcase
    last_byte  = (byte_cnt_q == {1'b0, len_q});
    page_end   = PW'(addr_q[7:0]) + PW'(len_q);
    page_cross = (page_end > PW'(255));
    rx_hit     = outst_q && qspi_rx_valid;
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    opc_d         = opc_q;
    len_d         = len_q;
    addr_d        = addr_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    outst_d       = outst_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    err_d         = err_q;
    cmd_ready     = 1'b0;
    qspi_tx_valid = 1'b0;
    qspi_tx_data  = 8'h00;
    qspi_rx_req   = 1'b0;
    wr_data_ready = 1'b0;
    txn_done      = 1'b0;
    txn_err       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          opc_d   = cmd_opcode;
          len_d   = cmd_len;
          addr_d  = cmd_addr;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        byte_cnt_d = '0;
        poll_cnt_d = POLL_LOAD;
        if ((opc_q != OP_READ && opc_q != OP_WRITE) || (opc_q == OP_WRITE && page_cross)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (opc_q == OP_READ) begin
          state_d = S_RD_CMD;
        end else begin
          state_d = S_WREN;
        end
      end
      S_RD_CMD, S_PG_CMD, S_WREN, S_POLL_CMD: begin
        qspi_tx_valid = 1'b1;
        case (state_q)
          S_RD_CMD: qspi_tx_data = RD_OPC;
          S_PG_CMD: qspi_tx_data = 8'h02;
          S_WREN:   qspi_tx_data = 8'h06;
          default:  qspi_tx_data = 8'h05;
        endcase
        if (qspi_tx_ready) begin
          byte_cnt_d = '0;
          case (state_q)
            S_RD_CMD: state_d = S_RD_ADDR;
            S_PG_CMD: state_d = S_PG_ADDR;
            S_POLL_CMD: state_d = S_POLL_RD;
            default: begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_LOAD;
              ret_d     = S_PG_CMD;
            end
          endcase
        end
      end
      S_RD_ADDR, S_PG_ADDR: begin
        qspi_tx_valid = 1'b1;
        qspi_tx_data  = addr_byte;
        if (qspi_tx_ready) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q[1:0] == 2'd2) begin
            byte_cnt_d = '0;
            if (state_q == S_PG_ADDR) state_d = S_PG_DATA;
            else                      state_d = FAST ? S_RD_DUMMY : S_RD_DATA;
          end
        end
      end
      S_RD_DUMMY: begin
        qspi_rx_req = !outst_q;
        if (rx_hit) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        // Only request a byte once the holding register has drained.
        qspi_rx_req = !outst_q && !rd_valid_q;
        if (rx_hit) begin
          rd_valid_d = 1'b1;
          rd_data_d  = qspi_rx_data;
        end
        if (rd_valid_q && rd_data_ready) begin
          rd_valid_d = 1'b0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (last_byte) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
            ret_d     = S_DONE;
          end
        end
      end
      S_PG_DATA: begin
        wr_data_ready = qspi_tx_ready;
        qspi_tx_valid = wr_data_valid;
        qspi_tx_data  = wr_data;
        if (wr_data_valid && qspi_tx_ready) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (last_byte) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
            ret_d     = S_POLL_CMD;
          end
        end
      end
      S_POLL_RD: begin
        qspi_rx_req = !outst_q;
        if (rx_hit) begin
          if (!qspi_rx_data[0]) begin
            state_d = S_DONE;
          end else if (poll_cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            poll_cnt_d = poll_cnt_q - 1'b1;
            state_d    = S_GAP;
            gap_cnt_d  = GAP_LOAD;
            ret_d      = S_POLL_CMD;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = ret_q;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      S_DONE: begin
        txn_done = 1'b1;
        txn_err  = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (qspi_rx_req) outst_d = 1'b1;
    else if (rx_hit) outst_d = 1'b0;
    cs_n_d = !in_frame(state_d);
  end

  // State and datapath registers; reset drops cs_n immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      opc_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      outst_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      err_q      <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      opc_q      <= opc_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      outst_q    <= outst_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      cs_n_q     <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_txn_fsm.sv
// Bench for txn_fsm: flash/controller and host models, queue scoreboard.
module tb_txn_fsm;
  localparam int OW = 4, LW = 8, CS_GAP = 4, POLL_MAX = 16;
`ifdef TXN_FSM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk, rst_n;
  logic cmd_valid, cmd_ready;
  logic [OW-1:0] cmd_opcode;
  logic [LW-1:0] cmd_len;
  logic [23:0] cmd_addr;
  logic wr_data_valid, wr_data_ready, rd_data_valid, rd_data_ready;
  logic [7:0] wr_data, rd_data, qspi_tx_data, qspi_rx_data;
  logic qspi_cs_n, qspi_tx_valid, qspi_tx_ready, qspi_rx_req, qspi_rx_valid;
  logic busy, txn_done, txn_err;

  txn_fsm #(.OPCODE_WIDTH(OW), .LEN_WIDTH(LW), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
    .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_data_ready(wr_data_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_ready(rd_data_ready),
    .qspi_cs_n(qspi_cs_n), .qspi_tx_valid(qspi_tx_valid), .qspi_tx_data(qspi_tx_data),
    .qspi_tx_ready(qspi_tx_ready), .qspi_rx_req(qspi_rx_req), .qspi_rx_valid(qspi_rx_valid),
    .qspi_rx_data(qspi_rx_data), .busy(busy), .txn_done(txn_done), .txn_err(txn_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_tx[$], exp_rd[$], resp_q[$], wr_src_q[$];
  bit exp_done[$];
  int done_cnt = 0, cs_low_cnt = 0, cyc = 0, hold_end = 0;
  bit rd_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Flash/controller model, host data model and output monitor.
  bit rx_out = 0, rd_pv = 0, rd_pa = 0, had_frame = 0, prev_cs = 1;
  int rx_dly = 0, gap_run = 0;
  logic [7:0] rd_pd = 8'h00;
  initial begin
    qspi_tx_ready = 0; qspi_rx_valid = 0; qspi_rx_data = 0;
    rd_data_ready = 0; wr_data_valid = 0; wr_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_out = 0; rd_pv = 0; had_frame = 0; gap_run = 0; prev_cs = 1;
      end else begin
        if (qspi_rx_req) begin
          chk("rx_req_single", {31'd0, rx_out}, 0);
          chk("rx_req_no_pending", {31'd0, rd_data_valid}, 0);
          chk("rx_req_in_frame", {31'd0, qspi_cs_n}, 0);
          rx_out = 1;
          rx_dly = $urandom_range(0, 3);
        end
        if (qspi_tx_valid && qspi_tx_ready) begin
          chk("tx_in_frame", {31'd0, qspi_cs_n}, 0);
          if (exp_tx.size() == 0) fail_now("tx_unexpected");
          else chk("tx_byte", {24'd0, qspi_tx_data}, {24'd0, exp_tx.pop_front()});
        end
        if (wr_data_valid && wr_data_ready && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
        if (rd_data_valid) begin
          if (rd_pv && !rd_pa) chk("rd_stable", {24'd0, rd_data}, {24'd0, rd_pd});
          if (rd_data_ready) begin
            if (exp_rd.size() == 0) fail_now("rd_unexpected");
            else chk("rd_byte", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
          end
        end
        rd_pv = rd_data_valid; rd_pa = rd_data_ready; rd_pd = rd_data;
        if (txn_done) begin
          chk("done_busy_low", {31'd0, busy}, 0);
          if (exp_done.size() == 0) fail_now("done_unexpected");
          else chk("done_err", {31'd0, txn_err}, {31'd0, exp_done.pop_front()});
          chk("tx_all_sent", exp_tx.size(), 0);
          chk("rd_all_recv", exp_rd.size(), 0);
          done_cnt++;
        end else if (txn_err) fail_now("err_without_done");
        if (cmd_valid && busy) chk("cmd_ready_while_busy", {31'd0, cmd_ready}, 0);
        if (!qspi_cs_n) cs_low_cnt++;
        if (busy) begin
          if (qspi_cs_n) gap_run++;
          else begin
            if (had_frame && prev_cs) chk("cs_gap", gap_run, CS_GAP);
            had_frame = 1; gap_run = 0;
          end
        end else begin
          had_frame = 0; gap_run = 0;
        end
        prev_cs = qspi_cs_n;
      end
      @(posedge clk); #1;
      cyc++;
      qspi_tx_ready = ($urandom_range(0, 3) != 0);
      qspi_rx_valid = 0;
      qspi_rx_data  = 8'($urandom);
      if (rx_out) begin
        if (rx_dly == 0) begin
          qspi_rx_valid = 1;
          rx_out = 0;
          if (resp_q.size() == 0) fail_now("rx_resp_underflow");
          else qspi_rx_data = resp_q.pop_front();
        end else rx_dly--;
      end else if ($urandom_range(0, 7) == 0) begin
        qspi_rx_valid = 1;
      end
      rd_data_ready = !rd_stall && (cyc >= hold_end) && ($urandom_range(0, 2) != 0);
      if (wr_src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        wr_data_valid = 1; wr_data = wr_src_q[0];
      end else begin
        wr_data_valid = 0; wr_data = 8'($urandom);
      end
    end
  end

  // Reference model: expected frames, read bytes and completion for one command.
  task automatic model_txn(input logic [3:0] opc, input logic [7:0] len, input logic [23:0] addr,
                           input int npolls, input bit timeout, input bit fixed);
    bit err;
    logic [7:0] b;
    int polls;
    err = !(opc == 4'h1 || opc == 4'h2) || (opc == 4'h2 && (int'(addr[7:0]) + int'(len) > 255));
    if (err) begin
      exp_done.push_back(1'b1);
      return;
    end
    exp_tx.push_back(opc == 4'h1 ? (FAST ? 8'h0B : 8'h03) : 8'h06);
    if (opc == 4'h2) exp_tx.push_back(8'h02);
    exp_tx.push_back(addr[23:16]); exp_tx.push_back(addr[15:8]); exp_tx.push_back(addr[7:0]);
    if (opc == 4'h1) begin
      if (FAST) resp_q.push_back(8'($urandom));
      for (int i = 0; i <= int'(len); i++) begin
        b = fixed ? 8'hA0 + 8'(i) : 8'($urandom);
        resp_q.push_back(b); exp_rd.push_back(b);
      end
      exp_done.push_back(1'b0);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        b = fixed ? (i == 0 ? 8'h5A : 8'hC3) : 8'($urandom);
        wr_src_q.push_back(b); exp_tx.push_back(b);
      end
      polls = timeout ? POLL_MAX : npolls;
      for (int p = 0; p < polls; p++) begin
        exp_tx.push_back(8'h05);
        if (timeout || p < polls - 1) resp_q.push_back(fixed ? 8'h01 : (8'($urandom) | 8'h01));
        else                          resp_q.push_back(fixed ? 8'h00 : (8'($urandom) & 8'hFE));
      end
      exp_done.push_back(timeout);
    end
  endtask

  task automatic issue(input logic [3:0] opc, input logic [7:0] len, input logic [23:0] addr,
                       input bit hold);
    bit acc = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_opcode = opc; cmd_len = len; cmd_addr = addr;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1; break; end
    end
    if (!acc) fail_now("cmd_accept_timeout");
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 0; cmd_opcode = 4'($urandom); cmd_len = 8'($urandom); cmd_addr = 24'($urandom);
    end
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 1);
    chk("cmd_ready_after_accept", {31'd0, cmd_ready}, 0);
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    int start = done_cnt;
    lat = -1;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt != start) begin lat = i; return; end
      @(negedge clk); #1;
    end
    if (done_cnt != start) lat = max_cyc;
    else fail_now("txn_done_timeout");
  endtask

  task automatic run(input logic [3:0] opc, input logic [7:0] len, input logic [23:0] addr,
                     input int npolls, input bit timeout, input bit fixed);
    int lat, cs0;
    bit err;
    err = !(opc == 4'h1 || opc == 4'h2) || (opc == 4'h2 && (int'(addr[7:0]) + int'(len) > 255));
    model_txn(opc, len, addr, npolls, timeout, fixed);
    cs0 = cs_low_cnt;
    issue(opc, len, addr, 1'b0);
    wait_done(6000, lat);
    if (err) begin
      chk("err_fast_done", {31'd0, lat <= 2}, 1);
      chk("err_no_frame", cs_low_cnt - cs0, 0);
    end
  endtask

  task automatic flush();
    exp_tx.delete(); exp_rd.delete(); resp_q.delete(); wr_src_q.delete(); exp_done.delete();
  endtask

  int lat;
  logic [7:0] rl, ra;
  int kind;
  initial begin
    rst_n = 0; cmd_valid = 0; cmd_opcode = 0; cmd_len = 0; cmd_addr = 0;
    #12;
    chk("rst_cs_n", {31'd0, qspi_cs_n}, 1);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_outs", {23'd0, busy, txn_done, txn_err, qspi_tx_valid, qspi_rx_req,
                     rd_data_valid, wr_data_ready, 2'b0}, 0);
    chk("rst_data", {16'd0, qspi_tx_data, rd_data}, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);

    run(4'h1, 8'd3, 24'h012345, 0, 0, 1);
    run(4'h2, 8'd1, 24'h000010, 3, 0, 1);
    run(4'h2, 8'h20, 24'h0000F0, 0, 0, 0);
    run(4'h2, 8'h0F, 24'h0000F0, 2, 0, 0);

    // Illegal opcode with cmd_valid held across the whole transaction.
    model_txn(4'h7, 8'd0, 24'h0, 0, 0, 0);
    issue(4'h7, 8'd0, 24'h0, 1'b1);
    wait_done(10, lat);
    chk("illegal_fast_done", {31'd0, lat <= 2}, 1);
    @(posedge clk); #1 cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("second_cmd_ignored", {31'd0, busy}, 0);

    // Host stall on the first read byte.
    rd_stall = 1;
    model_txn(4'h1, 8'd1, 24'h00ABCD, 0, 0, 0);
    issue(4'h1, 8'd1, 24'h00ABCD, 1'b0);
    for (int i = 0; i < 200 && !rd_data_valid; i++) @(negedge clk);
    chk("rd_valid_seen", {31'd0, rd_data_valid}, 1);
    hold_end = cyc + 10;
    rd_stall = 0;
    wait_done(2000, lat);

    // Poll limit: exactly POLL_MAX polls succeed, one more busy status times out.
    run(4'h2, 8'd0, 24'h000200, POLL_MAX, 0, 0);
    run(4'h2, 8'd0, 24'h000300, 0, 1, 0);
    run(4'h1, 8'd255, 24'h7FFF00, 0, 0, 0);
    run(4'h1, 8'd0, 24'hFFFFFF, 0, 0, 0);

    // Reset in the middle of the page-program data phase.
    model_txn(4'h2, 8'h3F, 24'h000100, 1, 0, 0);
    issue(4'h2, 8'h3F, 24'h000100, 1'b0);
    for (int i = 0; i < 500 && wr_src_q.size() > 60; i++) @(negedge clk);
    chk("pg_data_reached", {31'd0, wr_src_q.size() <= 60}, 1);
    chk("pg_data_cs_low", {31'd0, qspi_cs_n}, 0);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("abort_cs_n", {31'd0, qspi_cs_n}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run(4'h1, 8'd2, 24'h00C0DE, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 7);
      rl = 8'($urandom_range(0, 15));
      case (kind)
        0, 1, 2: run(4'h1, rl, 24'($urandom), 0, 0, 0);
        3, 4, 5: begin
          ra = 8'($urandom_range(0, 255 - int'(rl)));
          run(4'h2, rl, {16'($urandom), ra}, $urandom_range(1, 4), 0, 0);
        end
        6: begin
          if (rl == 0) rl = 8'd1;
          ra = 8'($urandom_range(256 - int'(rl), 255));
          run(4'h2, rl, {16'($urandom), ra}, 1, 0, 0);
        end
        default: run(4'($urandom_range(3, 15)), rl, 24'($urandom), 0, 0, 0);
      endcase
    end
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end
endmodule
